// File: rtl/spi_reg_target.sv
// spi_reg_target: SPI (mode 0) target that bridges serial frames onto a simple
// register bus. A frame is an 8-bit instruction, then an ADDR-bit address, then
// DATA data bits. Everything is MSB first.
//   Write frame: CMD_WR, addr, wdata -> one reg_we strobe
//   Read  frame: CMD_RD, addr, dummy -> one reg_re strobe, rdata shifted on miso
// All SPI pins are asynchronous to clk and are oversampled, so clk >= 8x sclk.
//
// Ports
//   clk, rst_n             system clock, async active-low reset
//   sclk, cs_n, mosi       SPI inputs from the master (async to clk)
//   miso, miso_oe          SPI output and its pad enable
//   reg_addr/reg_wdata     register bus address / write data
//   reg_we, reg_re         one-cycle write / read strobes
//   reg_rdata              read data, valid exactly one clk after reg_re
//   frame_err              one-cycle pulse on an aborted or unknown frame
module spi_reg_target #(
  parameter int         ADDR   = 16,
  parameter int         DATA   = 16,
  parameter logic [7:0] CMD_WR = 8'h02,
  parameter logic [7:0] CMD_RD = 8'h03
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  output logic [ADDR-1:0] reg_addr,
  output logic [DATA-1:0] reg_wdata,
  output logic            reg_we,
  output logic            reg_re,
  input  logic [DATA-1:0] reg_rdata,
  output logic            frame_err
);

  // Receive register is wide enough for the longest field.
  localparam int RXW = (ADDR > DATA) ? ((ADDR > 8) ? ADDR : 8)
                                     : ((DATA > 8) ? DATA : 8);
  localparam int CW  = $clog2(RXW + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  // ---------------------------------------------------------------------------
  // Synchronisers. Bit 0 is the first flop; bit 2 of sclk/cs_n is the extra
  // stage used only to detect edges on the already-synchronised bit 1.
  // Reset values are the idle bus levels so reset never manufactures an edge.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_s;
  logic [2:0] cs_s;
  logic [1:0] mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s   <= {cs_s[1:0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign mosi_bit  = mosi_s[1];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [RXW-1:0]  rx;
  logic [RXW-1:0]  rx_next;
  logic [DATA-1:0] tx;
  logic            is_rd;
  logic            oe_q;
  // Read launch pipeline: [0] address just latched, [1] reg_re on the bus,
  // [2] reg_rdata valid this cycle -> load the transmit register.
  logic [2:0]      vld_pipe;
  logic            addr_done;

  assign rx_next   = {rx[RXW-2:0], mosi_bit};
  assign addr_done = (state == ST_ADDR) && sclk_rise && !cs_rise &&
                     (cnt == CW'(ADDR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      is_rd     <= 1'b0;
      oe_q      <= 1'b0;
      vld_pipe  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
      oe_q      <= ~cs_s[1];
      vld_pipe  <= {vld_pipe[1:0], addr_done & is_rd};

      if (vld_pipe[2])
        tx <= reg_rdata;

      if (cs_rise) begin
        // Deselect before the data phase completed is an abort; a completed
        // frame has already moved on to ST_IGNORE.
        if (state inside {ST_CMD, ST_ADDR, ST_DATA})
          frame_err <= 1'b1;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state <= ST_CMD;
              cnt   <= '0;
            end
          end

          ST_CMD: begin
            if (sclk_rise) begin
              rx <= rx_next;
              if (cnt == CW'(7)) begin
                cnt <= '0;
                if (rx_next[7:0] == CMD_WR) begin
                  state <= ST_ADDR;
                  is_rd <= 1'b0;
                end else if (rx_next[7:0] == CMD_RD) begin
                  state <= ST_ADDR;
                  is_rd <= 1'b1;
                end else begin
                  state     <= ST_IGNORE;
                  frame_err <= 1'b1;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end

          ST_ADDR: begin
            if (sclk_rise) begin
              rx <= rx_next;
              if (addr_done) begin
                reg_addr <= rx_next[ADDR-1:0];
                cnt      <= '0;
                state    <= ST_DATA;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end

          ST_DATA: begin
            if (sclk_rise) begin
              rx <= rx_next;
              if (cnt == CW'(DATA - 1)) begin
                state <= ST_IGNORE;
                if (!is_rd) begin
                  reg_we    <= 1'b1;
                  reg_wdata <= rx_next[DATA-1:0];
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (sclk_fall && is_rd && (cnt != '0)) begin
              // The falling edge right after the address carries the MSB
              // unchanged; only edges that follow a sampled data bit advance.
              tx <= {tx[DATA-2:0], 1'b0};
            end
          end

          ST_IGNORE: ;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign reg_re  = vld_pipe[1];
  assign miso    = (state == ST_DATA) && is_rd && tx[DATA-1];
  // Raw cs_n gates the pad enable so it drops the moment the master deselects.
  assign miso_oe = oe_q & ~cs_n;

endmodule

// File: tb/tb_spi_reg_target.sv
module tb_spi_reg_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic [15:0] reg_addr, reg_wdata;
  logic [15:0] reg_rdata = 16'hDEAD;
  logic        reg_we, reg_re, frame_err;

  int vecs = 0;
  int errs = 0;

  int          we_cnt = 0, re_cnt = 0, err_cnt = 0, miso_hi = 0, both_cnt = 0;
  logic [15:0] we_addr = '0, we_data = '0, re_addr = '0;
  logic [15:0] rd_value = 16'h0000;

  always #5 clk = ~clk;

  spi_reg_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  // Register-file model: read data valid for exactly the cycle after reg_re.
  always @(posedge clk) reg_rdata <= reg_re ? rd_value : 16'hDEAD;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; end
    if (reg_re) begin re_cnt++; re_addr = reg_addr; end
    if (frame_err) err_cnt++;
    if (miso) miso_hi++;
    if (reg_we && reg_re) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SPI master, sclk = 10 clk periods. Inputs move on clk negedges.
  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    #100;
  endtask

  task automatic shift(input int n, input logic [63:0] d, output logic [63:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      #50;
      sclk = 1'b1;
      r = {r[62:0], miso};
      #50;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    #50;
    cs_n = 1'b1;
    mosi = 1'b0;
    #300;
  endtask

  task automatic test_reset();
    #50;
    vecs++; if ({miso, miso_oe, reg_we, reg_re, frame_err} !== 5'b0) begin
      errs++; $display("FAIL reset_strobes: got %b want 00000", {miso, miso_oe, reg_we, reg_re, frame_err}); end
    vecs++; if ({reg_addr, reg_wdata} !== 32'h0) begin
      errs++; $display("FAIL reset_bus: got %h want 00000000", {reg_addr, reg_wdata}); end
    @(negedge clk) rst_n = 1'b1;
    #100;
  endtask

  task automatic test_write();
    int w0, e0, r0;
    logic [63:0] r;
    w0 = we_cnt; e0 = err_cnt; r0 = re_cnt;
    cs_low();
    vecs++; if (miso_oe !== 1'b1) begin errs++; $display("FAIL write_oe_on: got %b want 1", miso_oe); end
    shift(40, 64'h02_0019_A00F, r);
    cs_high();
    vecs++; if (miso_oe !== 1'b0) begin errs++; $display("FAIL write_oe_off: got %b want 0", miso_oe); end
    vecs++; if (we_cnt - w0 !== 1) begin errs++; $display("FAIL write_we_count: got %0d want 1", we_cnt - w0); end
    vecs++; if (we_addr !== 16'h0019) begin errs++; $display("FAIL write_addr: got %h want 0019", we_addr); end
    vecs++; if (we_data !== 16'hA00F) begin errs++; $display("FAIL write_data: got %h want a00f", we_data); end
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL write_err: got %0d want 0", err_cnt - e0); end
    vecs++; if (re_cnt - r0 !== 0) begin errs++; $display("FAIL write_re: got %0d want 0", re_cnt - r0); end
  endtask

  task automatic test_read();
    int w0, e0, r0;
    logic [63:0] r;
    w0 = we_cnt; e0 = err_cnt; r0 = re_cnt;
    rd_value = 16'h1234;
    cs_low();
    shift(40, 64'h03_0019_0000, r);
    cs_high();
    vecs++; if (re_cnt - r0 !== 1) begin errs++; $display("FAIL read_re_count: got %0d want 1", re_cnt - r0); end
    vecs++; if (re_addr !== 16'h0019) begin errs++; $display("FAIL read_addr: got %h want 0019", re_addr); end
    vecs++; if (r[15:0] !== 16'h1234) begin errs++; $display("FAIL read_miso_data: got %h want 1234", r[15:0]); end
    vecs++; if (r[39:16] !== 24'h0) begin errs++; $display("FAIL read_miso_idle: got %h want 000000", r[39:16]); end
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL read_err: got %0d want 0", err_cnt - e0); end
    vecs++; if (we_cnt - w0 !== 0) begin errs++; $display("FAIL read_we: got %0d want 0", we_cnt - w0); end
    vecs++; if (both_cnt !== 0) begin errs++; $display("FAIL read_we_re_overlap: got %0d want 0", both_cnt); end
  endtask

  task automatic test_bad_cmd();
    int w0, e0, r0, m0;
    logic [63:0] r;
    w0 = we_cnt; e0 = err_cnt; r0 = re_cnt; m0 = miso_hi;
    cs_low();
    shift(40, 64'h55_FFFF_FFFF, r);
    cs_high();
    vecs++; if (err_cnt - e0 !== 1) begin errs++; $display("FAIL badcmd_err: got %0d want 1", err_cnt - e0); end
    vecs++; if ((we_cnt - w0) + (re_cnt - r0) !== 0) begin
      errs++; $display("FAIL badcmd_strobes: got %0d want 0", (we_cnt - w0) + (re_cnt - r0)); end
    vecs++; if (miso_hi - m0 !== 0) begin errs++; $display("FAIL badcmd_miso: got %0d high cycles want 0", miso_hi - m0); end
  endtask

  task automatic test_abort_write();
    int w0, e0;
    logic [63:0] r;
    w0 = we_cnt; e0 = err_cnt;
    cs_low();
    shift(34, {30'h0, 24'h020019, 10'h2AB}, r);
    cs_high();
    vecs++; if (we_cnt - w0 !== 0) begin errs++; $display("FAIL abortw_we: got %0d want 0", we_cnt - w0); end
    vecs++; if (err_cnt - e0 !== 1) begin errs++; $display("FAIL abortw_err: got %0d want 1", err_cnt - e0); end
    cs_low();
    shift(40, 64'h02_0042_BEEF, r);
    cs_high();
    vecs++; if (we_cnt - w0 !== 1) begin errs++; $display("FAIL abortw_next_we: got %0d want 1", we_cnt - w0); end
    vecs++; if ({we_addr, we_data} !== 32'h0042_BEEF) begin
      errs++; $display("FAIL abortw_next_word: got %h want 0042beef", {we_addr, we_data}); end
    vecs++; if (err_cnt - e0 !== 1) begin errs++; $display("FAIL abortw_next_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_extra_sclk();
    int w0, e0;
    logic [63:0] r;
    w0 = we_cnt; e0 = err_cnt;
    cs_low();
    shift(48, 64'h02_0007_5A5A_FF, r);
    cs_high();
    vecs++; if (we_cnt - w0 !== 1) begin errs++; $display("FAIL extra_we_count: got %0d want 1", we_cnt - w0); end
    vecs++; if ({we_addr, we_data} !== 32'h0007_5A5A) begin
      errs++; $display("FAIL extra_word: got %h want 00075a5a", {we_addr, we_data}); end
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL extra_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_read_abort();
    int w0, e0, r0;
    logic [63:0] r;
    w0 = we_cnt; e0 = err_cnt; r0 = re_cnt;
    rd_value = 16'hC3A5;
    cs_low();
    shift(28, {36'h0, 24'h030055, 4'h0}, r);
    cs_high();
    vecs++; if (re_cnt - r0 !== 1) begin errs++; $display("FAIL abortr_re: got %0d want 1", re_cnt - r0); end
    vecs++; if (err_cnt - e0 !== 1) begin errs++; $display("FAIL abortr_err: got %0d want 1", err_cnt - e0); end
    vecs++; if (r[3:0] !== 4'hC) begin errs++; $display("FAIL abortr_miso: got %h want c", r[3:0]); end
    vecs++; if (we_cnt - w0 !== 0) begin errs++; $display("FAIL abortr_we: got %0d want 0", we_cnt - w0); end
  endtask

  task automatic test_reset_midframe();
    int w0, e0, r0;
    logic [63:0] r;
    rd_value = 16'h8001;
    cs_low();
    shift(14, {50'h0, 8'h03, 6'h2A}, r);
    w0 = we_cnt; e0 = err_cnt; r0 = re_cnt;
    @(negedge clk) rst_n = 1'b0;
    #30;
    vecs++; if ({miso, miso_oe, reg_we, reg_re, frame_err} !== 5'b0) begin
      errs++; $display("FAIL midrst_strobes: got %b want 00000", {miso, miso_oe, reg_we, reg_re, frame_err}); end
    vecs++; if ({reg_addr, reg_wdata} !== 32'h0) begin
      errs++; $display("FAIL midrst_bus: got %h want 00000000", {reg_addr, reg_wdata}); end
    shift(4, 64'hF, r);
    cs_n = 1'b1;
    #50;
    @(negedge clk) rst_n = 1'b1;
    #300;
    cs_low();
    shift(40, 64'h03_0123_0000, r);
    cs_high();
    vecs++; if (re_cnt - r0 !== 1) begin errs++; $display("FAIL midrst_re: got %0d want 1", re_cnt - r0); end
    vecs++; if (re_addr !== 16'h0123) begin errs++; $display("FAIL midrst_addr: got %h want 0123", re_addr); end
    vecs++; if (r[15:0] !== 16'h8001) begin errs++; $display("FAIL midrst_miso: got %h want 8001", r[15:0]); end
    vecs++; if ((err_cnt - e0) + (we_cnt - w0) !== 0) begin
      errs++; $display("FAIL midrst_spurious: got %0d want 0", (err_cnt - e0) + (we_cnt - w0)); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_abort_write();
    test_extra_sclk();
    test_read_abort();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spi_reg_target.md
SPI_REG_TARGET -- requirements
Module: spi_reg_target

Interface
REQ-001 Parameter ADDR, default 16: register address width in bits.
REQ-002 Parameter DATA, default 16: register data width in bits.
REQ-003 Parameter CMD_WR, default 8'h02: instruction byte selecting a write frame.
REQ-004 Parameter CMD_RD, default 8'h03: instruction byte selecting a read frame.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 sclk  in  1  SPI clock from master, asynchronous to clk, mode 0.
REQ-009 cs_n  in  1  SPI chip select, active low, asynchronous to clk.
REQ-010 mosi  in  1  SPI serial data in, MSB first.
REQ-011 miso  out  1  SPI serial data out, MSB first.
REQ-012 miso_oe  out  1  miso output enable, high only while cs_n is low.
REQ-013 reg_addr  out  ADDR  register address, held stable from the end of the address phase until the frame ends.
REQ-014 reg_wdata  out  DATA  register write data, valid while reg_we is high.
REQ-015 reg_we  out  1  one-cycle write strobe.
REQ-016 reg_re  out  1  one-cycle read strobe.
REQ-017 reg_rdata  in  DATA  read data, valid exactly one clk after reg_re.
REQ-018 frame_err  out  1  one-cycle pulse on an aborted or unknown-instruction frame.

Function
REQ-019 The block SHALL synchronise sclk, cs_n and mosi through two flip-flops each and SHALL use a third stage for sclk/cs_n edge detection; it requires clk >= 8x sclk.
REQ-020 The block SHALL implement states ST_IDLE, ST_CMD, ST_ADDR, ST_DATA and ST_IGNORE.
REQ-021 The FSM SHALL move from ST_IDLE to ST_CMD on a synchronised cs_n falling edge and clear its bit counter.
REQ-022 On each synchronised sclk rising edge in ST_CMD, ST_ADDR or ST_DATA, the block SHALL shift mosi into the receive register MSB first.
REQ-023 After 8 bits in ST_CMD: CMD_WR or CMD_RD -> ST_ADDR; any other value -> ST_IGNORE with one frame_err pulse.
REQ-024 After ADDR bits in ST_ADDR, the block SHALL latch reg_addr and enter ST_DATA.
REQ-025 For a read frame, the block SHALL pulse reg_re in the clk cycle after the address is latched, SHALL capture reg_rdata one clk later into the transmit register, and SHALL drive its MSB on miso before the next synchronised sclk falling edge.
REQ-026 During ST_DATA of a read frame, miso SHALL advance one bit on each synchronised sclk falling edge; in all other states miso SHALL be 0.
REQ-027 For a write frame, on the DATA-th bit sampled in ST_DATA, the block SHALL pulse reg_we for one cycle with reg_wdata equal to the received word and reg_addr equal to the latched address.
REQ-028 After the DATA-th data bit, the FSM SHALL enter ST_IGNORE; there is no address auto-increment, and extra sclk edges are discarded.
REQ-029 A synchronised cs_n rising edge in any state SHALL return the FSM to ST_IDLE.
REQ-030 A cs_n rising edge before completion of a write data phase SHALL suppress reg_we and pulse frame_err once.
REQ-031 A cs_n rising edge during a read data phase SHALL pulse frame_err once and SHALL NOT issue a second reg_re.
REQ-032 A cs_n falling edge coinciding with a cs_n rising-edge abort cannot occur after synchronisation; a new frame SHALL start only from ST_IDLE.
REQ-033 reg_we and reg_re SHALL never be high in the same cycle, and each SHALL occur at most once per frame.

Reset
REQ-034 While rst_n is low: state ST_IDLE; miso, miso_oe, reg_we, reg_re and frame_err at 0; reg_addr and reg_wdata at 0; synchroniser flops at idle levels (sclk 0, cs_n 1).
REQ-035 Reset asserted mid-frame SHALL abandon the frame without any strobe; after release the block SHALL wait for a fresh cs_n falling edge.

Verification
REQ-036 Write frame 02 0019 A00F, clk = 10x sclk -> exactly one reg_we with reg_addr=16'h0019 and reg_wdata=16'hA00F; no frame_err.
REQ-037 Read frame 03 0019 0000, reg_rdata=16'h1234 -> one reg_re with reg_addr=16'h0019; miso carries 16'h1234 MSB first on the data bits.
REQ-038 Instruction 8'h55 followed by 32 bits -> one frame_err, no reg_we or reg_re, miso stays 0.
REQ-039 Write frame with cs_n raised after 10 data bits -> no reg_we, one frame_err; the next full write frame commits normally.
REQ-040 Write frame followed by 8 extra sclk cycles before cs_n high -> a single reg_we only, with no second strobe.
REQ-041 rst_n pulsed low mid-address, then a complete read frame -> all outputs at 0 during reset; the read completes correctly.
